// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: multi-tap circular delay line for echo/chorus/flanger effects.
// One sample is written per input strobe; the single synchronous read port is
// then time-multiplexed to return NUM_TAPS delayed samples, published together
// with a one-cycle TAP_VALID pulse.
// Optional build macro DELAY_LINE_FEEDBACK_EN: the written sample becomes
// sat(SAMPLE_IN + (tap0 >>> FB_SHIFT)), turning the line into a regenerating echo.
module delay_line_ctrl #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 15,
  parameter int SIZE       = 20000,
  parameter int NUM_TAPS   = 2,
  parameter int FB_SHIFT   = 1
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           SAMPLE_IN_VALID,
  input  logic signed [DATA_WIDTH-1:0]   SAMPLE_IN,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0] DELAY,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] TAP_OUT,
  output logic                           TAP_VALID,
  output logic                           BUSY,
  output logic                           OVERRUN
);

  localparam int KW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0]   SIZE_X = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] MAX_D  = ADDR_WIDTH'(SIZE - 1);
  localparam logic [KW-1:0]         LAST_K = KW'(NUM_TAPS - 1);

  logic [1:0]                    state;
  logic [ADDR_WIDTH-1:0]         wptr;
  logic [ADDR_WIDTH:0]           fill;
  logic [KW-1:0]                 k;

  logic signed [DATA_WIDTH-1:0]  sample_p0;
  logic signed [DATA_WIDTH-1:0]  wr_data;
  logic signed [DATA_WIDTH-1:0]  mem [SIZE];

  logic [ADDR_WIDTH-1:0]         delay_sel;
  logic [ADDR_WIDTH-1:0]         d_clamp;
  logic [ADDR_WIDTH:0]           raddr_x;
  logic [ADDR_WIDTH-1:0]         raddr;

  logic signed [DATA_WIDTH-1:0]  rd_data_p1;
  logic [KW-1:0]                 rd_slot_p1;
  logic                          rd_ok_p1;
  logic                          vld_p1;

  logic signed [DATA_WIDTH-1:0]  tap_q [NUM_TAPS];

`ifdef DELAY_LINE_FEEDBACK_EN
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // One-bit-wider add; disagreeing top two bits means the result left the signed range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = $signed({a[DATA_WIDTH-1], a}) + $signed({b[DATA_WIDTH-1], b});
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      return s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    return s[DATA_WIDTH-1:0];
  endfunction

  // Slot 0 only changes during READ/DONE, so in WRITE it still holds the
  // previous completed frame's value (0 after reset) and serves as feedback.
  assign wr_data = sat_add(sample_p0, tap_q[0] >>> FB_SHIFT);
`else
  assign wr_data = sample_p0;
`endif

  // Select the delay of the tap being issued, clamp it and form the wrapped read address.
  always_comb begin
    delay_sel = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (k == KW'(i)) delay_sel = DELAY[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    d_clamp = (delay_sel > MAX_D) ? MAX_D : delay_sel;
    if (wptr >= d_clamp) raddr_x = {1'b0, wptr} - {1'b0, d_clamp};
    else                 raddr_x = {1'b0, wptr} + SIZE_X - {1'b0, d_clamp};
    raddr = raddr_x[ADDR_WIDTH-1:0];
  end

  // Frame sequencer: IDLE -> WRITE -> READ x NUM_TAPS -> DONE, plus overrun and valid flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      wptr      <= '0;
      fill      <= '0;
      k         <= '0;
      vld_p1    <= 1'b0;
      TAP_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      TAP_VALID <= 1'b0;
      vld_p1    <= 1'b0;
      if (SAMPLE_IN_VALID && state != S_IDLE) OVERRUN <= 1'b1;
      case (state)
        S_IDLE: begin
          if (SAMPLE_IN_VALID) state <= S_WRITE;
        end
        S_WRITE: begin
          k     <= '0;
          state <= S_READ;
        end
        S_READ: begin
          vld_p1 <= 1'b1;
          k      <= k + 1'b1;
          if (k == LAST_K) state <= S_DONE;
        end
        default: begin
          wptr      <= (wptr == MAX_D) ? '0 : wptr + 1'b1;
          fill      <= (fill == SIZE_X) ? fill : fill + 1'b1;
          TAP_VALID <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Sample latch and RAM read stage; a tap is usable only if its delay reaches written data.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && SAMPLE_IN_VALID) sample_p0 <= SAMPLE_IN;
    rd_data_p1 <= mem[raddr];
    rd_slot_p1 <= k;
    rd_ok_p1   <= ({1'b0, d_clamp} <= fill);
  end

  // RAM write port; contents are never cleared, the fill count masks stale words.
  always_ff @(posedge CLK) begin
    if (state == S_WRITE) mem[wptr] <= wr_data;
  end

  // ---- stage p1 -> output: capture each returned word into its tap slot ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_TAPS; i++) tap_q[i] <= '0;
    end else if (vld_p1) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (rd_slot_p1 == KW'(i)) tap_q[i] <= rd_ok_p1 ? rd_data_p1 : '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_pack
    assign TAP_OUT[g*DATA_WIDTH +: DATA_WIDTH] = tap_q[g];
  end

  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl (SIZE=16, NUM_TAPS=2, ADDR_WIDTH=5).
// Stimulus pushes hand-computed tap values and arrival cycle; a monitor pops on TAP_VALID.
`timescale 1ns/1ps
module tb_delay_line_ctrl;
  localparam int DW  = 31;
  localparam int AW  = 5;
  localparam int SZ  = 16;
  localparam int NT  = 2;
  localparam int FBS = 1;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 SAMPLE_IN_VALID = 1'b0;
  logic signed [DW-1:0] SAMPLE_IN = '0;
  logic [NT*AW-1:0]     DELAY = '0;
  logic [NT*DW-1:0]     TAP_OUT;
  logic                 TAP_VALID;
  logic                 BUSY;
  logic                 OVERRUN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string            name;
    logic [NT*DW-1:0] exp;
    int               at;
  } exp_t;
  exp_t sb[$];

  delay_line_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ), .NUM_TAPS(NT), .FB_SHIFT(FBS)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .SAMPLE_IN_VALID(SAMPLE_IN_VALID), .SAMPLE_IN(SAMPLE_IN),
    .DELAY(DELAY), .TAP_OUT(TAP_OUT), .TAP_VALID(TAP_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Strobe one sample; if push is set, record the expected taps and arrival cycle.
  task automatic send(input int v, input int d0, input int d1,
                      input int e0, input int e1, input string nm, input bit push);
    exp_t e;
    @(negedge CLK);
    SAMPLE_IN       = DW'(v);
    DELAY           = {AW'(d1), AW'(d0)};
    SAMPLE_IN_VALID = 1'b1;
    if (push) begin
      e.name = nm;
      e.exp  = {DW'(e1), DW'(e0)};
      e.at   = cyc + NT + 3;
      sb.push_back(e);
    end
    @(negedge CLK);
    SAMPLE_IN_VALID = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge CLK);
          if (TAP_VALID) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_tap_valid: got TAP_VALID=1, expected 0 (cycle %0d)", cyc);
            end else begin
              exp_t e;
              e = sb.pop_front();
              check(e.name, TAP_OUT, e.exp);
              check({e.name, "_latency"}, cyc, e.at);
            end
          end
        end
      end
      begin : stimulus
        // Reset state, held and released.
        gap(2);
        check("rst_tap_out", TAP_OUT, 0);
        check("rst_tap_valid", TAP_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_overrun", OVERRUN, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        gap(2);
        check("rel_tap_out", TAP_OUT, 0);
        check("rel_busy", BUSY, 0);

        // First frame: delay 0 returns the sample, delay 3 is unwritten.
        send(100, 0, 3, 100, 0, "t1_first", 1'b1);
        check("t1_busy_high", BUSY, 1);
        gap(5);
        check("t1_busy_low", BUSY, 0);

        // Steady stream across the wptr wrap; delay 20 clamps to 15 after 30 samples.
        do_reset();
        for (int n = 1; n <= 40; n++) begin
          send(n, 5, (n <= 30) ? 15 : 20, (n > 5) ? n - 5 : 0, (n > 15) ? n - 15 : 0,
               (n <= 30) ? "t2_stream" : "t3_clamp", 1'b1);
          gap(4);
        end
        check("t2_overrun_clear", OVERRUN, 0);

        // Overrun: second back-to-back strobe is dropped.
        do_reset();
        @(negedge CLK);
        begin
          exp_t e;
          SAMPLE_IN = DW'(7);
          DELAY = {AW'(1), AW'(0)};
          SAMPLE_IN_VALID = 1'b1;
          e.name = "t4_first";
          e.exp = {DW'(0), DW'(7)};
          e.at = cyc + NT + 3;
          sb.push_back(e);
        end
        @(negedge CLK);
        SAMPLE_IN = DW'(9);
        @(negedge CLK);
        SAMPLE_IN_VALID = 1'b0;
        gap(4);
        check("t4_overrun_set", OVERRUN, 1);
        send(11, 0, 1, 11, 7, "t4_dropped", 1'b1);
        gap(4);
        check("t4_overrun_sticky", OVERRUN, 1);

        // Mid-frame reset during READ abandons the frame.
        send(21, 0, 0, 21, 21, "t5_pre", 1'b1);
        gap(4);
        send(22, 0, 0, 0, 0, "", 1'b0);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("t5_rst_busy", BUSY, 0);
        check("t5_rst_overrun", OVERRUN, 0);
        check("t5_rst_tap_out", TAP_OUT, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        gap(6);
        send(55, 2, 0, 0, 55, "t5_after_a", 1'b1);
        gap(4);
        send(56, 2, 0, 0, 56, "t5_after_b", 1'b1);
        gap(4);
        send(57, 2, 0, 55, 57, "t5_after_c", 1'b1);
        gap(4);

`ifdef DELAY_LINE_FEEDBACK_EN
        // Regenerating echo: each written value is half the previous tap 0.
        do_reset();
        send(1000, 0, 0, 1000, 1000, "t6_fb_1000", 1'b1);
        gap(4);
        send(0, 0, 0, 500, 500, "t6_fb_500", 1'b1);
        gap(4);
        send(0, 0, 0, 250, 250, "t6_fb_250", 1'b1);
        gap(4);
        send(0, 0, 0, 125, 125, "t6_fb_125", 1'b1);
        gap(4);
        do_reset();
        send(2**30 - 1, 0, 0, 2**30 - 1, 2**30 - 1, "t6_sat_a", 1'b1);
        gap(4);
        send(2**30 - 1, 0, 0, 2**30 - 1, 2**30 - 1, "t6_sat_b", 1'b1);
        gap(4);
`endif

        gap(8);
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL pending_frames: got %0d outstanding, expected 0", sb.size());
        end
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
